// File: rtl/ones_comp_pkg.sv
// Shared types and helpers for the bit-serial ones'-complement adder.
package ones_comp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    WRAP,
    DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int cntWidth(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder shared by both serial passes.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Y,
  output logic Cout
);

  assign Y    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/ones_comp_serial_adder.sv
// Bit-serial ones'-complement adder: add pass, then end-around-carry pass.
// Optional: ONES_COMP_NEG_ZERO_NORM_EN maps negative zero to positive zero.
module ones_comp_serial_adder
  import ones_comp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             end_carry
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, nextState;

  logic [WIDTH-1:0] aSr, bSr, resSr, yQ, yNext;
  logic [CW-1:0]    cnt;
  logic             carryQ, endCarryQ, ecQ, doneQ;
  logic             faA, faB, faCin, faSum, faCout;
  logic             lastBit;

  assign lastBit = (cnt == LAST);

  full_adder u_fa (
    .A   (faA),
    .B   (faB),
    .Cin (faCin),
    .Y   (faSum),
    .Cout(faCout)
  );

  // Second pass adds end_carry at bit 0 only; carry ripples from there.
  always_comb begin
    faA   = 1'b0;
    faB   = 1'b0;
    faCin = 1'b0;
    unique case (1'b1)
      (state == ADD): begin
        faA   = aSr[0];
        faB   = bSr[0];
        faCin = carryQ;
      end
      (state == WRAP): begin
        faA   = resSr[0];
        faB   = (cnt == '0) ? endCarryQ : 1'b0;
        faCin = (cnt == '0) ? 1'b0 : carryQ;
      end
      default: ;
    endcase
  end

`ifdef ONES_COMP_NEG_ZERO_NORM_EN
  assign yNext = (&resSr) ? '0 : resSr;
`else
  assign yNext = resSr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (start)   nextState = ADD;
      ADD:  if (lastBit) nextState = WRAP;
      WRAP: if (lastBit) nextState = DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aSr       <= '0;
      bSr       <= '0;
      resSr     <= '0;
      yQ        <= '0;
      cnt       <= '0;
      carryQ    <= 1'b0;
      endCarryQ <= 1'b0;
      ecQ       <= 1'b0;
      doneQ     <= 1'b0;
    end else begin
      doneQ <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            aSr    <= A;
            bSr    <= B;
            carryQ <= 1'b0;
            cnt    <= '0;
          end
        end
        ADD: begin
          aSr    <= aSr >> 1;
          bSr    <= bSr >> 1;
          resSr  <= {faSum, resSr[WIDTH-1:1]};
          carryQ <= faCout;
          cnt    <= lastBit ? '0 : cnt + 1'b1;
          if (lastBit) endCarryQ <= faCout;
        end
        WRAP: begin
          resSr  <= {faSum, resSr[WIDTH-1:1]};
          carryQ <= faCout;
          cnt    <= lastBit ? '0 : cnt + 1'b1;
        end
        DONE: begin
          yQ  <= yNext;
          ecQ <= endCarryQ;
        end
        default: ;
      endcase
    end
  end

  // done is registered out of DONE, so busy must cover that cycle too.
  always_comb begin
    busy      = (state != IDLE) | doneQ;
    done      = doneQ;
    Y         = yQ;
    end_carry = ecQ;
  end

endmodule
